// File: rtl/irq_ctrl.sv
// irq_ctrl: aggregates N_SRC edge/level interrupt sources onto one irq line with id,
// one source presented at a time, closed by a matching ack and a programmable hold-off.
module irq_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_SRC-1:0] src_i,
  input  logic             cfg_we,
  input  logic             cfg_re,
  input  logic [1:0]       cfg_addr,
  input  logic [N_SRC-1:0] cfg_wdata,
  output logic [N_SRC-1:0] cfg_rdata,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             ack,
  input  logic [ID_W-1:0]  ack_id
);
  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK, HOLDOFF} state_e;
  state_e state_q, state_d;
  logic [N_SRC-1:0] src_q, en_q, en_d, edge_q, edge_d, pend_q, pend_d;
  logic [N_SRC-1:0] pending, elig, w1c, clr, rd_mux;
  logic [7:0] hold_q, hold_d, cnt_q, cnt_d;
  logic [ID_W-1:0] id_q, id_d, low;
  logic ack_hit;
  assign en_d    = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : en_q;
  assign edge_d  = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : edge_q;
  assign hold_d  = (cfg_we && cfg_addr == 2'd3) ? 8'(cfg_wdata) : hold_q;
  assign w1c     = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : '0;
  assign clr     = ack_hit ? (N_SRC'(1) << id_q) : '0;
  // a fresh rising edge is OR'd in after both clears so it can never be lost
  assign pend_d  = ((pend_q & ~w1c & ~clr) | (src_i & ~src_q)) & edge_q;
  assign pending = (pend_q & edge_q) | (src_q & ~edge_q);
  assign elig    = pending & en_q;
  assign rd_mux  = cfg_addr == 2'd0 ? en_q :
                   cfg_addr == 2'd1 ? edge_q :
                   cfg_addr == 2'd2 ? pending : N_SRC'(hold_q);
  assign irq     = (state_q == ASSERT) || (state_q == WAIT_ACK);
  assign irq_id  = id_q;
  always_comb begin
    low = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (elig[i]) low = ID_W'(i);
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    ack_hit = 1'b0;
    case (state_q)
      IDLE: if (|elig) begin
        state_d = ASSERT;
        id_d    = low;
      end
      ASSERT: state_d = WAIT_ACK;
      WAIT_ACK: if (ack && ack_id == id_q) begin
        ack_hit = 1'b1;
        cnt_d   = hold_q;
        state_d = hold_q == 8'd0 ? IDLE : HOLDOFF;
      end
      default: begin
        cnt_d   = cnt_q - 8'd1;
        state_d = cnt_q == 8'd1 ? IDLE : HOLDOFF;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      src_q     <= '0;
      en_q      <= '0;
      edge_q    <= '0;
      pend_q    <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      cfg_rdata <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_i;
      en_q      <= en_d;
      edge_q    <= edge_d;
      pend_q    <= pend_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      cfg_rdata <= cfg_re ? rd_mux : cfg_rdata;
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenario tasks for irq_ctrl with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_irq_ctrl;
  localparam int N = 8;
  localparam int IW = 3;
  logic clk = 1'b0, rstn = 1'b0, cfg_we = 1'b0, cfg_re = 1'b0, ack = 1'b0, irq;
  logic [N-1:0] src_i = '0, cfg_wdata = '0, cfg_rdata, rv;
  logic [1:0] cfg_addr = '0;
  logic [IW-1:0] ack_id = '0, irq_id;
  int nvec = 0, nerr = 0;

  irq_ctrl #(.N_SRC(N), .ID_W(IW)) dut (
    .clk(clk), .rstn(rstn), .src_i(src_i), .cfg_we(cfg_we), .cfg_re(cfg_re),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq(irq), .irq_id(irq_id), .ack(ack), .ack_id(ack_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [N-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [N-1:0] d);
    cfg_re = 1'b1; cfg_addr = a;
    tick();
    cfg_re = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic do_ack(input logic [IW-1:0] id);
    ack = 1'b1; ack_id = id;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL reset_irq: got %0b want 0", irq); end
    nvec++; if (irq_id !== 3'd0) begin nerr++; $display("FAIL reset_id: got %0d want 0", irq_id); end
    nvec++; if (cfg_rdata !== 8'h00) begin nerr++; $display("FAIL reset_rdata: got %h want 00", cfg_rdata); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), rv);
      nvec++; if (rv !== 8'h00) begin nerr++; $display("FAIL reset_reg%0d: got %h want 00", a, rv); end
    end
  endtask

  task automatic test_edge();
    wr(2'd1, 8'h01);
    wr(2'd0, 8'h01);
    rd(2'd1, rv);
    nvec++; if (rv !== 8'h01) begin nerr++; $display("FAIL edge_rd_edge: got %h want 01", rv); end
    src_i = 8'h01;
    tick();
    src_i = 8'h00;
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL edge_k: got %0b want 0", irq); end
    tick();
    nvec++; if (irq !== 1'b1 || irq_id !== 3'd0) begin nerr++; $display("FAIL edge_k1: got irq=%0b id=%0d want 1/0", irq, irq_id); end
    tick();
    do_ack(3'd0);
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL edge_ack_drop: got %0b want 0", irq); end
    rd(2'd2, rv);
    nvec++; if (rv !== 8'h00) begin nerr++; $display("FAIL edge_pending: got %h want 00", rv); end
    tick(); tick();
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL edge_no_repeat: got %0b want 0", irq); end
  endtask

  task automatic test_priority();
    wr(2'd1, 8'hFF);
    wr(2'd0, 8'hFF);
    src_i = 8'h24;
    tick();
    src_i = 8'h00;
    tick();
    nvec++; if (irq !== 1'b1 || irq_id !== 3'd2) begin nerr++; $display("FAIL prio_first: got irq=%0b id=%0d want 1/2", irq, irq_id); end
    do_ack(3'd2);
    nvec++; if (irq !== 1'b1 || irq_id !== 3'd2) begin nerr++; $display("FAIL prio_ack_in_assert: got irq=%0b id=%0d want 1/2", irq, irq_id); end
    do_ack(3'd2);
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL prio_ack_drop: got %0b want 0", irq); end
    tick();
    nvec++; if (irq !== 1'b1 || irq_id !== 3'd5) begin nerr++; $display("FAIL prio_second: got irq=%0b id=%0d want 1/5", irq, irq_id); end
    tick();
    do_ack(3'd5);
    rd(2'd2, rv);
    nvec++; if (rv !== 8'h00 || irq !== 1'b0) begin nerr++; $display("FAIL prio_done: got pend=%h irq=%0b want 00/0", rv, irq); end
  endtask

  task automatic test_holdoff();
    wr(2'd1, 8'h00);
    wr(2'd3, 8'h04);
    rd(2'd3, rv);
    nvec++; if (rv !== 8'h04) begin nerr++; $display("FAIL hold_rd: got %h want 04", rv); end
    src_i = 8'h08;
    tick(); tick();
    nvec++; if (irq !== 1'b1 || irq_id !== 3'd3) begin nerr++; $display("FAIL hold_present: got irq=%0b id=%0d want 1/3", irq, irq_id); end
    tick();
    do_ack(3'd3);
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL hold_low0: got %0b want 0", irq); end
    for (int i = 1; i < 5; i++) begin
      tick();
      nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL hold_low%0d: got %0b want 0", i, irq); end
    end
    tick();
    nvec++; if (irq !== 1'b1 || irq_id !== 3'd3) begin nerr++; $display("FAIL hold_repres: got irq=%0b id=%0d want 1/3", irq, irq_id); end
    tick();
    src_i = 8'h00;
    do_ack(3'd3);
    for (int i = 0; i < 6; i++) tick();
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL hold_released: got %0b want 0", irq); end
    wr(2'd3, 8'h00);
  endtask

  task automatic test_wrong_ack();
    wr(2'd1, 8'h01);
    src_i = 8'h01;
    tick();
    src_i = 8'h00;
    tick(); tick();
    do_ack(3'd1);
    nvec++; if (irq !== 1'b1 || irq_id !== 3'd0) begin nerr++; $display("FAIL wack_ignored: got irq=%0b id=%0d want 1/0", irq, irq_id); end
    wr(2'd0, 8'h00);
    tick(); tick();
    nvec++; if (irq !== 1'b1 || irq_id !== 3'd0) begin nerr++; $display("FAIL wack_masked_hold: got irq=%0b id=%0d want 1/0", irq, irq_id); end
    do_ack(3'd0);
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL wack_drop: got %0b want 0", irq); end
    src_i = 8'h01;
    tick();
    src_i = 8'h00;
    tick(); tick();
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL wack_disabled: got %0b want 0", irq); end
    rd(2'd2, rv);
    nvec++; if (rv !== 8'h01) begin nerr++; $display("FAIL wack_pending: got %h want 01", rv); end
    wr(2'd2, 8'h01);
    rd(2'd2, rv);
    nvec++; if (rv !== 8'h00) begin nerr++; $display("FAIL wack_w1c: got %h want 00", rv); end
  endtask

  task automatic test_set_wins();
    wr(2'd1, 8'h04);
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'h04; src_i = 8'h04;
    tick();
    cfg_we = 1'b0; src_i = 8'h00;
    rd(2'd2, rv);
    nvec++; if (rv !== 8'h04) begin nerr++; $display("FAIL setwin_pending: got %h want 04", rv); end
    wr(2'd2, 8'h04);
    rd(2'd2, rv);
    nvec++; if (rv !== 8'h00) begin nerr++; $display("FAIL setwin_w1c: got %h want 00", rv); end
    cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'h5A;
    tick();
    cfg_we = 1'b0; cfg_re = 1'b0;
    nvec++; if (cfg_rdata !== 8'h00) begin nerr++; $display("FAIL rw_old: got %h want 00", cfg_rdata); end
    rd(2'd0, rv);
    nvec++; if (rv !== 8'h5A) begin nerr++; $display("FAIL rw_new: got %h want 5a", rv); end
    wr(2'd0, 8'h00);
  endtask

  task automatic test_reset_mid();
    wr(2'd1, 8'h02);
    wr(2'd0, 8'h02);
    wr(2'd3, 8'h05);
    src_i = 8'h02;
    tick();
    src_i = 8'h00;
    tick();
    nvec++; if (irq !== 1'b1 || irq_id !== 3'd1) begin nerr++; $display("FAIL rmid_present: got irq=%0b id=%0d want 1/1", irq, irq_id); end
    tick();
    do_ack(3'd1);
    rd(2'd0, rv);
    tick();
    nvec++; if (irq !== 1'b0 || cfg_rdata !== 8'h02) begin nerr++; $display("FAIL rmid_pre: got irq=%0b rdata=%h want 0/02", irq, cfg_rdata); end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    nvec++; if (irq !== 1'b0 || irq_id !== 3'd0 || cfg_rdata !== 8'h00) begin nerr++; $display("FAIL rmid_after: got irq=%0b id=%0d rdata=%h want 0/0/00", irq, irq_id, cfg_rdata); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), rv);
      nvec++; if (rv !== 8'h00) begin nerr++; $display("FAIL rmid_reg%0d: got %h want 00", a, rv); end
    end
    src_i = 8'h02;
    for (int i = 0; i < 6; i++) tick();
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL rmid_quiet: got %0b want 0", irq); end
    wr(2'd0, 8'h02);
    tick();
    nvec++; if (irq !== 1'b1 || irq_id !== 3'd1) begin nerr++; $display("FAIL rmid_reenable: got irq=%0b id=%0d want 1/1", irq, irq_id); end
    src_i = 8'h00;
    tick();
    do_ack(3'd1);
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL rmid_final_ack: got %0b want 0", irq); end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_priority();
    test_holdoff();
    test_wrong_ack();
    test_set_wins();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
